// File: rtl/piso_arbiter.sv
// piso_arbiter: round-robin arbiter feeding one requester nibble at a time
// to a 4-bit serializer, with completion ack, timeout abort and frame count.
`default_nettype none

module piso_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] req_data,
  input  logic [3:0]  ch_en,
  output logic [3:0]  ack,
  output logic [3:0]  ser_data,
  output logic        ser_valid,
  input  logic        ser_done,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        timeout_err,
  output logic [7:0]  frame_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      last_grant;
  logic [1:0]      winner;
  logic [1:0]      cand;
  logic            found;
  logic [3:0]      eligible;
  logic [CW-1:0]   wait_cnt;
  logic            do_load, do_ack, do_timeout;

  // Search starts one past the last winner; i=4 wraps back onto last_grant.
  always_comb begin
    eligible = req & ch_en;
    winner   = last_grant;
    found    = 1'b0;
    cand     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_ack     = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          do_load   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = WAIT;
      WAIT: begin
        // A done arriving on the last allowed cycle still completes the transfer.
        if (ser_done) begin
          do_ack    = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack         <= 4'd0;
      ser_valid   <= 1'b0;
      ser_data    <= 4'd0;
      grant_id    <= 2'd0;
      timeout_err <= 1'b0;
      frame_cnt   <= 8'd0;
      last_grant  <= 2'd3;
      wait_cnt    <= '0;
    end else begin
      ser_valid   <= do_load;
      timeout_err <= do_timeout;
      ack         <= do_ack ? (4'b0001 << grant_id) : 4'd0;
      if (do_load) begin
        grant_id <= winner;
        ser_data <= req_data[{winner, 2'b00} +: 4];
      end
      if (do_ack || do_timeout) last_grant <= grant_id;
      if (do_ack) frame_cnt <= frame_cnt + 8'd1;
      if (state == LOAD)      wait_cnt <= CW'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      else                    wait_cnt <= '0;
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_piso_arbiter.sv
// tb_piso_arbiter: directed and randomized checks of piso_arbiter against a
// transaction-level reference model.
`default_nettype none

module tb_piso_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ch_en;
  logic [3:0]  ack;
  logic [3:0]  ser_data;
  logic        ser_valid;
  logic        ser_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  piso_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ch_en(ch_en),
    .ack(ack), .ser_data(ser_data), .ser_valid(ser_valid), .ser_done(ser_done),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=idle, 1=load, 2=wait
  int       m_phase, m_wait, m_last, m_gid, m_cnt;
  logic [3:0] m_ack, m_data;
  logic     m_valid, m_to;

  // Stimulus controls and observation logs
  int  done_mode = 0;   // 0 never, 1 fixed delay, 2 random
  int  done_delay = 1;
  bit  rand_mode = 0;
  int  grants[$];
  int  ack_log[$];
  int  acks_seen, to_seen, stepno, v_step, t_step;
  bit  ack0_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] e;
    if (rst) begin
      m_phase = 0; m_wait = 0; m_last = 3; m_gid = 0; m_data = 0;
      m_cnt = 0; m_ack = 0; m_valid = 0; m_to = 0;
    end else begin
      m_ack = 0; m_valid = 0; m_to = 0;
      case (m_phase)
        0: begin
          e = req & ch_en;
          if (e != 0) begin
            for (int k = 1; k <= 4; k++) begin
              if (e[(m_last + k) % 4]) begin
                m_gid = (m_last + k) % 4;
                break;
              end
            end
            m_data  = req_data[4*m_gid +: 4];
            m_valid = 1;
            m_phase = 1;
          end
        end
        1: begin
          m_phase = 2;
          m_wait  = 1;
        end
        default: begin
          if (ser_done) begin
            m_ack   = 4'b0001 << m_gid;
            m_last  = m_gid;
            m_cnt   = (m_cnt + 1) % 256;
            m_phase = 0;
          end else if (m_wait == TIMEOUT) begin
            m_to    = 1;
            m_last  = m_gid;
            m_phase = 0;
          end else begin
            m_wait++;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    stepno++;
    chk("ack", ack, m_ack);
    chk("ser_valid", ser_valid, m_valid);
    chk("ser_data", ser_data, m_data);
    chk("busy", busy, (m_phase != 0));
    chk("grant_id", grant_id, m_gid[1:0]);
    chk("timeout_err", timeout_err, m_to);
    chk("frame_cnt", frame_cnt, m_cnt[7:0]);
    if (ser_valid === 1'b1) begin
      grants.push_back(int'(grant_id));
      if (v_step < 0) v_step = stepno;
    end
    if (ack != 4'd0) begin
      acks_seen++;
      if (ack[0]) ack0_seen = 1;
      for (int b = 0; b < 4; b++) if (ack[b]) ack_log.push_back(b);
    end
    if (timeout_err === 1'b1) begin
      to_seen++;
      t_step = stepno;
    end
    case (done_mode)
      0:       ser_done = 1'b0;
      1:       ser_done = (m_phase == 2 && m_wait == done_delay);
      default: ser_done = ($urandom % 4 == 0);
    endcase
    if (rand_mode) begin
      for (int n = 0; n < 4; n++) begin
        if (m_ack[n]) req[n] = 1'($urandom % 2);
        else if (!req[n] && $urandom % 4 == 0) begin
          req[n] = 1'b1;
          req_data[4*n +: 4] = 4'($urandom);
        end else if (req[n] && $urandom % 50 == 0) req[n] = 1'b0;
      end
      if ($urandom % 20 == 0) ch_en = 4'($urandom);
      rst = ($urandom % 500 == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    grants.delete();
    ack_log.delete();
    acks_seen = 0; to_seen = 0; stepno = 0; v_step = -1; t_step = -1; ack0_seen = 0;
  endtask

  initial begin
    int exp_rr[5];
    int bad;
    exp_rr = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = 4'd0; req_data = 16'd0; ch_en = 4'hF; ser_done = 1'b0;
    step();
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_grant_id", grant_id, 0);

    // Single request, done five wait cycles after load
    req_data = 16'h000A; req = 4'b0001; done_mode = 1; done_delay = 5;
    repeat (12) begin
      step();
      if (m_ack != 0) req = req & ~m_ack;
    end
    chk("single_acks", acks_seen, 1);
    chk("single_ack_idx", (ack_log.size() > 0) ? ack_log[0] : 99, 0);
    chk("single_data", ser_data, 4'hA);
    chk("single_frame_cnt", frame_cnt, 1);

    // Round-robin with all requesters held
    do_reset();
    req = 4'hF; req_data = 16'h4321; done_delay = 2;
    repeat (25) step();
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", (i < grants.size()) ? grants[i] : 99, exp_rr[i]);
      chk("rr_ack", (i < ack_log.size()) ? ack_log[i] : 99, exp_rr[i]);
    end

    // Mask: requester 0 requests but is disabled
    do_reset();
    req = 4'b0011; ch_en = 4'b0010; done_delay = 3;
    repeat (30) step();
    bad = 0;
    foreach (grants[i]) if (grants[i] != 1) bad++;
    chk("mask_grants_made", grants.size() > 0, 1);
    chk("mask_only_req1", bad, 0);
    chk("mask_no_ack0", ack0_seen, 0);

    // Timeout: serializer never answers
    do_reset();
    req = 4'hF; ch_en = 4'hF; done_mode = 0;
    repeat (20) step();
    chk("to_pulses", to_seen, 1);
    chk("to_latency", t_step - v_step, TIMEOUT + 1);
    chk("to_no_ack", acks_seen, 0);
    chk("to_frame_cnt", frame_cnt, 0);
    chk("to_next_grant", (grants.size() > 1) ? grants[1] : 99, 1);

    // Done on the final allowed wait cycle beats the timeout
    do_reset();
    done_mode = 1; done_delay = TIMEOUT;
    repeat (20) step();
    chk("edge_acks", acks_seen, 1);
    chk("edge_no_timeout", to_seen, 0);

    // Reset while waiting abandons the transfer
    do_reset();
    req = 4'b0010; done_mode = 0;
    repeat (5) step();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'd0;
    chk("mid_outputs_zero", {ack, ser_valid, ser_data, busy, grant_id, timeout_err, frame_cnt}, 0);
    ser_done = 1'b1;
    step();
    chk("mid_done_ignored_cnt", frame_cnt, 0);
    chk("mid_done_ignored_ack", ack, 0);
    grants.delete();
    req = 4'hF;
    repeat (3) step();
    chk("mid_next_grant", (grants.size() > 0) ? grants[0] : 99, 0);

    // Randomized traffic with occasional resets
    do_reset();
    req = 4'd0; rand_mode = 1; done_mode = 2;
    repeat (3000) step();
    rand_mode = 0;
    rst = 1'b0;

    // Frame counter wrap after 256 completions
    do_reset();
    req = 4'hF; ch_en = 4'hF; done_mode = 1; done_delay = 1;
    for (int i = 0; i < 2000 && acks_seen < 256; i++) step();
    chk("wrap_acks", acks_seen, 256);
    chk("wrap_frame_cnt", frame_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
